// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared types and screen index constants for the screen cross-fade mux
//
// Contents:
//   rgb_t         12-bit packed RGB pixel (4 bits per channel, R in [11:8])
//   chan_t        single 4-bit colour channel
//   screen_id_t   well-known screen source indices
//   xfade_state_t cross-fade controller states

package screen_pkg;

    typedef logic [11:0] rgb_t;
    typedef logic [3:0]  chan_t;

    typedef enum logic [2:0] {
        SCR_MENU  = 3'd0,
        SCR_GAME  = 3'd1,
        SCR_OVER  = 3'd2,
        SCR_PAUSE = 3'd3
    } screen_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } xfade_state_t;

endpackage

// File: rtl/xfade_blend.sv
// rtl/xfade_blend.sv - combinational single-channel linear blender
//
// blend_px = (old_px * (2**FADE_LOG2 - alpha) + new_px * alpha) >> FADE_LOG2
//
// Ports:
//   old_px   in   4            outgoing screen channel value
//   new_px   in   4            incoming screen channel value
//   alpha    in   FADE_LOG2+1  weight of new_px, 0..2**FADE_LOG2
//   blend_px out  4            blended channel, truncated (no rounding)

module xfade_blend
    import screen_pkg::*;
#(
    parameter int FADE_LOG2 = 4
) (
    input  chan_t              old_px,
    input  chan_t              new_px,
    input  logic [FADE_LOG2:0] alpha,
    output chan_t              blend_px
);

    localparam int                 AW         = FADE_LOG2 + 1;
    localparam int                 W          = 4 + FADE_LOG2 + 1;
    localparam logic [AW-1:0]      FADE_MAX_A = AW'(2 ** FADE_LOG2);

    logic [AW-1:0] inv_alpha;
    logic [W-1:0]  prod_old;
    logic [W-1:0]  prod_new;
    logic [W-1:0]  sum;

    // The two weights always add up to FADE_MAX, so the sum never exceeds
    // 15 * FADE_MAX and fits in W bits without overflow.
    assign inv_alpha = FADE_MAX_A - alpha;
    assign prod_old  = W'(old_px) * W'(inv_alpha);
    assign prod_new  = W'(new_px) * W'(alpha);
    assign sum       = prod_old + prod_new;
    assign blend_px  = chan_t'(sum >> FADE_LOG2);

endmodule

// File: rtl/screen_xfade_mux.sv
// rtl/screen_xfade_mux.sv - frame-synchronous screen selector with optional cross-fade
//
// Build option: define SCREEN_XFADE_EN for the cross-fade; without it a
// request switches screens hard on the next frame_tick.
//
// Ports:
//   clk        in   1             pixel clock
//   rst_n      in   1             synchronous active-low reset
//   state      in   SEL_W         requested screen index (out-of-range ignored)
//   frame_tick in   1             one-cycle pulse per frame
//   rgb_src    in   N_SCREENS*12  per-screen pixel, aligned to this cycle
//   rgb_out    out  12            blended pixel, 2 cycles after rgb_src
//   busy       out  1             transition in progress or pending
//   cur_sel    out  SEL_W         screen faded in or fading in

module screen_xfade_mux
    import screen_pkg::*;
#(
    parameter int N_SCREENS = 4,
    parameter int FADE_LOG2 = 4,
    parameter int SEL_W     = $clog2(N_SCREENS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           state,
    input  logic                       frame_tick,
    input  logic [N_SCREENS-1:0][11:0] rgb_src,
    output logic [11:0]                rgb_out,
    output logic                       busy,
    output logic [SEL_W-1:0]           cur_sel
);

    localparam int            AW         = FADE_LOG2 + 1;
    localparam logic [AW-1:0] FADE_MAX_A = AW'(2 ** FADE_LOG2);

    // Compare-based mux so SEL_W may be wider than needed for N_SCREENS.
    function automatic rgb_t pick(input logic [N_SCREENS-1:0][11:0] src,
                                  input logic [SEL_W-1:0]           sel);
        rgb_t r;
        r = '0;
        for (int i = 0; i < N_SCREENS; i++) begin
            if (sel == SEL_W'(i)) r = src[i];
        end
        return r;
    endfunction

    logic             req_ok;
    logic [SEL_W-1:0] cur_nxt;
    logic [SEL_W-1:0] pend_sel;
    logic [SEL_W-1:0] pend_sel_nxt;
    logic             pend_v;
    logic             pend_v_nxt;
    logic [AW-1:0]    alpha;
    rgb_t             new_q;

    assign req_ok = (32'(state) < N_SCREENS);

`ifdef SCREEN_XFADE_EN

    xfade_state_t     fsm;
    xfade_state_t     fsm_nxt;
    logic [SEL_W-1:0] prev_sel;
    logic [SEL_W-1:0] prev_nxt;
    logic [AW-1:0]    alpha_nxt;
    logic [AW-1:0]    alpha_q;
    rgb_t             old_q;
    rgb_t             blend_px;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            cur_sel  <= SEL_W'(SCR_MENU);
            prev_sel <= SEL_W'(SCR_MENU);
            pend_sel <= '0;
            pend_v   <= 1'b0;
            alpha    <= FADE_MAX_A;
        end else begin
            fsm      <= fsm_nxt;
            cur_sel  <= cur_nxt;
            prev_sel <= prev_nxt;
            pend_sel <= pend_sel_nxt;
            pend_v   <= pend_v_nxt;
            alpha    <= alpha_nxt;
        end
    end

    always_comb begin
        fsm_nxt      = fsm;
        cur_nxt      = cur_sel;
        prev_nxt     = prev_sel;
        pend_sel_nxt = pend_sel;
        pend_v_nxt   = pend_v;
        alpha_nxt    = alpha;
        case (fsm)
            IDLE: begin
                // frame_tick is deliberately ignored here, so a tick in the
                // acceptance cycle does not advance the new fade.
                if (req_ok && (state != cur_sel)) begin
                    prev_nxt  = cur_sel;
                    cur_nxt   = state;
                    alpha_nxt = '0;
                    fsm_nxt   = FADE;
                end
            end
            FADE: begin
                if (frame_tick && (alpha == FADE_MAX_A - AW'(1))) begin
                    if (pend_v) begin
                        // Chain straight into the queued fade; the request
                        // is consumed on this edge.
                        prev_nxt   = cur_sel;
                        cur_nxt    = pend_sel;
                        alpha_nxt  = '0;
                        pend_v_nxt = 1'b0;
                    end else begin
                        alpha_nxt = FADE_MAX_A;
                        fsm_nxt   = IDLE;
                    end
                end else begin
                    if (frame_tick) alpha_nxt = alpha + AW'(1);
                    // Latest request wins; asking for the screen already
                    // fading in cancels anything queued.
                    if (req_ok) begin
                        pend_sel_nxt = state;
                        pend_v_nxt   = (state != cur_sel);
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    assign busy = (fsm != IDLE) | pend_v;

    // Stage 1 samples the selects and alpha alongside their own pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            old_q   <= '0;
            new_q   <= '0;
            alpha_q <= FADE_MAX_A;
            rgb_out <= '0;
        end else begin
            old_q   <= pick(rgb_src, prev_sel);
            new_q   <= pick(rgb_src, cur_sel);
            alpha_q <= alpha;
            rgb_out <= blend_px;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        xfade_blend #(
            .FADE_LOG2 (FADE_LOG2)
        ) u_blend (
            .old_px   (old_q[4*c +: 4]),
            .new_px   (new_q[4*c +: 4]),
            .alpha    (alpha_q),
            .blend_px (blend_px[4*c +: 4])
        );
    end

`else

    logic unused_alpha;

    // Without the fade, weight stays at full scale; kept for observability.
    assign alpha        = FADE_MAX_A;
    assign unused_alpha = ^alpha;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_sel  <= SEL_W'(SCR_MENU);
            pend_sel <= '0;
            pend_v   <= 1'b0;
        end else begin
            cur_sel  <= cur_nxt;
            pend_sel <= pend_sel_nxt;
            pend_v   <= pend_v_nxt;
        end
    end

    // Requests wait for a frame boundary so the switch never tears.
    always_comb begin
        cur_nxt      = cur_sel;
        pend_sel_nxt = pend_sel;
        pend_v_nxt   = pend_v;
        if (frame_tick && pend_v) begin
            cur_nxt    = pend_sel;
            pend_v_nxt = 1'b0;
        end else if (req_ok) begin
            pend_sel_nxt = state;
            pend_v_nxt   = (state != cur_sel);
        end
    end

    assign busy = pend_v;

    // Two register stages keep the same latency as the fading build.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            new_q   <= '0;
            rgb_out <= '0;
        end else begin
            new_q   <= pick(rgb_src, cur_sel);
            rgb_out <= new_q;
        end
    end

`endif

endmodule

// File: tb/tb_screen_xfade_mux.sv
// tb/tb_screen_xfade_mux.sv - scoreboard bench for screen_xfade_mux (both build options)

module tb_screen_xfade_mux;
    import screen_pkg::*;

    localparam int NS   = 4;
    localparam int FL   = 4;
    localparam int SW   = 3;
    localparam int FMAX = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [SW-1:0]       state;
    logic                frame_tick;
    logic [NS-1:0][11:0] rgb_src;
    logic [11:0]         rgb_out;
    logic                busy;
    logic [SW-1:0]       cur_sel;

    always #5 clk = ~clk;

    screen_xfade_mux #(
        .N_SCREENS (NS),
        .FADE_LOG2 (FL),
        .SEL_W     (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .frame_tick (frame_tick),
        .rgb_src    (rgb_src),
        .rgb_out    (rgb_out),
        .busy       (busy),
        .cur_sel    (cur_sel)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    typedef struct {
        string       tag;
        int          due;
        logic [11:0] exp;
    } px_t;

    px_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        px_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            if (e.due == cyc) chk(e.tag, 32'(rgb_out), 32'(e.exp));
            else              chk({e.tag, "_due"}, cyc, e.due);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [11:0] e);
        px_t p;
        p.tag = tag;
        p.due = cyc + 2;
        p.exp = e;
        sb_q.push_back(p);
    endtask

    task automatic run_px(input string tag, input logic [11:0] e, input int n);
        repeat (n) begin
            push(tag, e);
            step(1);
        end
    endtask

    task automatic frame_px(input string tag, input logic [11:0] e);
        push(tag, e);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
        end
    endtask

    function automatic logic [11:0] mix(input logic [11:0] o, input logic [11:0] nw, input int a);
        logic [11:0] r;
        for (int c = 0; c < 3; c++) begin
            int v;
            v = (int'(o[4*c +: 4]) * (FMAX - a) + int'(nw[4*c +: 4]) * a) >> FL;
            r[4*c +: 4] = v[3:0];
        end
        return r;
    endfunction

    initial begin
        rst_n      = 1'b0;
        state      = '0;
        frame_tick = 1'b0;
        rgb_src[0] = 12'hABC;
        rgb_src[1] = 12'h0F0;
        rgb_src[2] = 12'h00F;
        rgb_src[3] = 12'h555;

        step(3);
        chk("rst_rgb", 32'(rgb_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur", 32'(cur_sel), 0);
        chk("rst_alpha", 32'(dut.alpha), FMAX);

        rst_n = 1'b1;
        run_px("rel_px", 12'hABC, 4);
        chk("rel_busy", 32'(busy), 0);

`ifdef SCREEN_XFADE_EN
        rgb_src[0] = 12'hF00;
        run_px("idle_px", 12'hF00, 2);
        state = SW'(SCR_GAME);
        run_px("acc_px", 12'hF00, 1);
        chk("acc_cur", 32'(cur_sel), 1);
        chk("acc_busy", 32'(busy), 1);
        chk("acc_alpha", 32'(dut.alpha), 0);
        run_px("a0_px", 12'hF00, 2);
        for (int a = 0; a < 8; a++) begin
            frame_px("fade_lo", mix(12'hF00, 12'h0F0, a));
            run_px("fade_lo", mix(12'hF00, 12'h0F0, a + 1), 1);
        end
        chk("alpha8", 32'(dut.alpha), 8);
        run_px("a8_px", 12'h770, 2);
        for (int a = 8; a < 16; a++) begin
            frame_px("fade_hi", mix(12'hF00, 12'h0F0, a));
            if (a < 15) run_px("fade_hi", mix(12'hF00, 12'h0F0, a + 1), 1);
        end
        chk("end_busy", 32'(busy), 0);
        chk("end_alpha", 32'(dut.alpha), FMAX);
        run_px("a16_px", 12'h0F0, 3);

        // back to 0, then 0->1 with queued requests
        state = SW'(SCR_MENU);
        step(1);
        frame(16);
        chk("back_cur", 32'(cur_sel), 0);
        chk("back_busy", 32'(busy), 0);
        state = SW'(SCR_GAME);
        step(3);
        state = SW'(SCR_OVER);
        step(1);
        chk("pend2_v", 32'(dut.pend_v), 1);
        chk("pend2_sel", 32'(dut.pend_sel), 2);
        state = SW'(SCR_GAME);
        step(1);
        chk("pend_clr", 32'(dut.pend_v), 0);
        state = SW'(SCR_OVER);
        step(1);
        state = SW'(SCR_PAUSE);
        step(2);
        chk("pend3_sel", 32'(dut.pend_sel), 3);
        chk("pend3_v", 32'(dut.pend_v), 1);
        chk("pend3_busy", 32'(busy), 1);
        frame(16);
        chk("chain_cur", 32'(cur_sel), 3);
        chk("chain_prev", 32'(dut.prev_sel), 1);
        chk("chain_alpha", 32'(dut.alpha), 0);
        chk("chain_busy", 32'(busy), 1);
        chk("chain_pv", 32'(dut.pend_v), 0);
        run_px("chain_px", 12'h0F0, 2);
        frame(16);
        chk("chain_done", 32'(busy), 0);

        // out-of-range request
        state = 3'd7;
        step(3);
        chk("oor_busy", 32'(busy), 0);
        chk("oor_cur", 32'(cur_sel), 3);

        // tick coincident with acceptance
        state = SW'(SCR_MENU);
        step(1);
        frame(16);
        chk("t4_cur", 32'(cur_sel), 0);
        state = SW'(SCR_OVER);
        frame(1);
        chk("tc_alpha", 32'(dut.alpha), 0);
        chk("tc_cur", 32'(cur_sel), 2);
        chk("tc_busy", 32'(busy), 1);

        // reset mid-fade
        frame(5);
        chk("mid_alpha", 32'(dut.alpha), 5);
        rst_n = 1'b0;
        state = SW'(SCR_MENU);
        step(1);
        chk("mr_cur", 32'(cur_sel), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_alpha", 32'(dut.alpha), FMAX);
        rst_n = 1'b1;
        step(2);
        chk("mr_idle", 32'(busy), 0);
`else
        rgb_src[0] = 12'hF00;
        run_px("hc_idle", 12'hF00, 2);
        state = SW'(SCR_GAME);
        run_px("hc_req", 12'hF00, 1);
        chk("hc_busy", 32'(busy), 1);
        chk("hc_cur", 32'(cur_sel), 0);
        chk("hc_alpha", 32'(dut.alpha), FMAX);
        run_px("hc_wait", 12'hF00, 4);
        chk("hc_busy2", 32'(busy), 1);
        frame_px("hc_tick", 12'hF00);
        chk("hc_sw_cur", 32'(cur_sel), 1);
        chk("hc_sw_busy", 32'(busy), 0);
        run_px("hc_new", 12'h0F0, 3);

        // latest request wins
        state = SW'(SCR_OVER);
        step(1);
        state = SW'(SCR_PAUSE);
        step(2);
        chk("lw_sel", 32'(dut.pend_sel), 3);
        frame(1);
        chk("lw_cur", 32'(cur_sel), 3);
        chk("lw_busy", 32'(busy), 0);

        // request back to current screen cancels
        state = SW'(SCR_MENU);
        step(1);
        chk("cl_busy1", 32'(busy), 1);
        state = SW'(SCR_PAUSE);
        step(1);
        chk("cl_busy0", 32'(busy), 0);
        frame(1);
        chk("cl_cur", 32'(cur_sel), 3);

        // out-of-range request
        state = 3'd7;
        step(2);
        chk("oor_busy", 32'(busy), 0);
        frame(1);
        chk("oor_cur", 32'(cur_sel), 3);

        // tick coincident with request: switch waits for the next tick
        state = SW'(SCR_OVER);
        frame(1);
        chk("tc_cur", 32'(cur_sel), 3);
        chk("tc_busy", 32'(busy), 1);
        frame(1);
        chk("tc_cur2", 32'(cur_sel), 2);
        chk("tc_busy2", 32'(busy), 0);

        // reset while pending
        state = SW'(SCR_MENU);
        step(1);
        chk("rp_busy", 32'(busy), 1);
        rst_n = 1'b0;
        step(1);
        chk("rp_cur", 32'(cur_sel), 0);
        chk("rp_busy0", 32'(busy), 0);
        rst_n = 1'b1;
        step(1);
`endif

        step(4);
        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
